div_issue_ctrl: RTL and testbench

//  Requester side of the sequential divider's Start/Done handshake.
//  - Accepts RISC-V M-extension divide/remainder ops (DIV, DIVU, REM, REMU) from the execute stage.
//  - Resolves divide-by-zero and signed overflow locally; otherwise converts operands to magnitudes.
//  - Launches the divider, waits for completion, applies sign fix-up and returns one tagged result.
//  - Sits between the EX stage and the div instance; the pipeline stalls while ReqReady=0.

---
 rtl/div_issue_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_div_issue_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/div_issue_ctrl.sv
// Requester side of the sequential divider Start/Done handshake: accepts RISC-V
// DIV/DIVU/REM/REMU, resolves corner cases locally and sign-fixes divider results.
module div_issue_ctrl #(
    parameter int MSB = 31
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_req_valid,
    output logic         o_req_ready,
    input  logic [1:0]   i_req_op,
    input  logic [MSB:0] i_req_rs1,
    input  logic [MSB:0] i_req_rs2,
    input  logic [4:0]   i_req_rd,
    input  logic         i_flush,
    output logic         o_rsp_valid,
    output logic [MSB:0] o_rsp_data,
    output logic [4:0]   o_rsp_rd,
    output logic         o_div_start,
    output logic [MSB:0] o_div_divident,
    output logic [MSB:0] o_div_divisor,
    input  logic         i_div_done,
    input  logic [MSB:0] i_div_quotient,
    input  logic [MSB:0] i_div_remainder
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_WAIT   = 3'd2,
        S_RESP   = 3'd3,
        S_DRAIN  = 3'd4
    } state_t;

    localparam logic [MSB:0] ZERO    = {(MSB+1){1'b0}};
    localparam logic [MSB:0] ONES    = {(MSB+1){1'b1}};
    localparam logic [MSB:0] MIN_NEG = {1'b1, {MSB{1'b0}}};

    function automatic logic [MSB:0] negate(input logic [MSB:0] x);
        return ~x + {{MSB{1'b0}}, 1'b1};
    endfunction

    function automatic logic [MSB:0] magnitude(input logic [MSB:0] x, input logic is_signed);
        logic [MSB:0] res;
        if (is_signed && x[MSB]) begin
            res = negate(x);
        end else begin
            res = x;
        end
        return res;
    endfunction

    state_t       r_state;
    state_t       w_next_state;
    logic         r_req_ready;
    logic         r_div_start;
    logic [MSB:0] r_rsp_data;
    logic [4:0]   r_rsp_rd;
    logic [MSB:0] r_div_divident;
    logic [MSB:0] r_div_divisor;
    logic         r_is_rem;
    logic         r_negate;

    logic         w_accept;
    logic         w_signed;
    logic         w_is_rem;
    logic         w_div_zero;
    logic         w_overflow;
    logic         w_special;
    logic [MSB:0] w_special_data;
    logic [MSB:0] w_raw_result;
    logic [MSB:0] w_fixed_result;

    // Request decode and locally resolved results (divide-by-zero, signed overflow)
    always_comb begin
        w_accept       = i_req_valid && (r_state == S_IDLE) && !i_flush;
        w_signed       = !i_req_op[0];
        w_is_rem       = i_req_op[1];
        w_div_zero     = (i_req_rs2 == ZERO);
        w_overflow     = w_signed && (i_req_rs1 == MIN_NEG) && (i_req_rs2 == ONES);
        w_special      = w_div_zero || w_overflow;
        if (w_div_zero) begin
            w_special_data = w_is_rem ? i_req_rs1 : ONES;
        end else begin
            w_special_data = w_is_rem ? ZERO : i_req_rs1;
        end
        w_raw_result   = r_is_rem ? i_div_remainder : i_div_quotient;
        w_fixed_result = r_negate ? negate(w_raw_result) : w_raw_result;
    end

    // Next-state logic; Flush wins over divider completion
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next_state = w_special ? S_RESP : S_LAUNCH;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_LAUNCH: begin
                // Divider samples the start pulse this cycle, so a flush must still drain
                w_next_state = i_flush ? S_DRAIN : S_WAIT;
            end
            S_WAIT: begin
                if (i_flush) begin
                    w_next_state = S_DRAIN;
                end else if (i_div_done) begin
                    w_next_state = S_RESP;
                end else begin
                    w_next_state = S_WAIT;
                end
            end
            S_RESP: begin
                w_next_state = S_IDLE;
            end
            S_DRAIN: begin
                w_next_state = i_div_done ? S_IDLE : S_DRAIN;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // State register with ready/start decoded one cycle ahead
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_req_ready <= 1'b1;
            r_div_start <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_req_ready <= (w_next_state == S_IDLE);
            r_div_start <= (w_next_state == S_LAUNCH);
        end
    end

    // Operand, tag and sign capture on accept; held until the next accept
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_div_divident <= ZERO;
            r_div_divisor  <= ZERO;
            r_rsp_rd       <= 5'd0;
            r_is_rem       <= 1'b0;
            r_negate       <= 1'b0;
        end else if (w_accept) begin
            r_div_divident <= magnitude(i_req_rs1, w_signed);
            r_div_divisor  <= magnitude(i_req_rs2, w_signed);
            r_rsp_rd       <= i_req_rd;
            r_is_rem       <= w_is_rem;
            r_negate       <= w_signed && (w_is_rem ? i_req_rs1[MSB]
                                                    : (i_req_rs1[MSB] ^ i_req_rs2[MSB]));
        end else begin
            r_div_divident <= r_div_divident;
            r_div_divisor  <= r_div_divisor;
            r_rsp_rd       <= r_rsp_rd;
            r_is_rem       <= r_is_rem;
            r_negate       <= r_negate;
        end
    end

    // Result register: special-case value at accept, sign-fixed divider output on completion
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rsp_data <= ZERO;
        end else if (w_accept && w_special) begin
            r_rsp_data <= w_special_data;
        end else if ((r_state == S_WAIT) && i_div_done && !i_flush) begin
            r_rsp_data <= w_fixed_result;
        end else begin
            r_rsp_data <= r_rsp_data;
        end
    end

    // A flush in the response cycle must be able to cancel the strobe, so it stays combinational
    assign o_rsp_valid    = (r_state == S_RESP) && !i_flush && !i_reset;
    assign o_req_ready    = r_req_ready;
    assign o_div_start    = r_div_start;
    assign o_rsp_data     = r_rsp_data;
    assign o_rsp_rd       = r_rsp_rd;
    assign o_div_divident = r_div_divident;
    assign o_div_divisor  = r_div_divisor;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Scoreboard bench for div_issue_ctrl: directed corner cases plus randomized ops,
// with a behavioural sequential-divider model attached to the handshake.
module tb_div_issue_ctrl;
    localparam int MSB   = 31;
    localparam int LAT_N = MSB + 5;
    localparam int BUSY  = MSB + 2;

    logic         clk = 1'b0;
    logic         reset;
    logic         req_valid, req_ready, flush;
    logic [1:0]   req_op;
    logic [MSB:0] req_rs1, req_rs2;
    logic [4:0]   req_rd;
    logic         rsp_valid, div_start, div_done;
    logic [MSB:0] rsp_data, div_a, div_b, div_q, div_r;
    logic [4:0]   rsp_rd;

    div_issue_ctrl #(.MSB(MSB)) dut (
        .i_clk(clk), .i_reset(reset), .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_req_op(req_op), .i_req_rs1(req_rs1), .i_req_rs2(req_rs2), .i_req_rd(req_rd),
        .i_flush(flush), .o_rsp_valid(rsp_valid), .o_rsp_data(rsp_data), .o_rsp_rd(rsp_rd),
        .o_div_start(div_start), .o_div_divident(div_a), .o_div_divisor(div_b),
        .i_div_done(div_done), .i_div_quotient(div_q), .i_div_remainder(div_r)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Sequential divider model: busy for BUSY cycles after a sampled start, garbage outputs while busy
    int           d_cnt = 0;
    logic [MSB:0] d_q, d_r, d_a, d_b, d_garb;
    always @(posedge clk) begin
        d_garb <= $urandom;
        if (reset) d_cnt <= 0;
        else if (d_cnt != 0) d_cnt <= d_cnt - 1;
        else if (div_start) begin
            d_cnt <= BUSY;
            d_a   <= div_a;
            d_b   <= div_b;
            d_q   <= (div_b == 0) ? '1 : div_a / div_b;
            d_r   <= (div_b == 0) ? div_a : div_a % div_b;
        end
    end
    assign div_done = (d_cnt == 0);
    assign div_q    = div_done ? d_q : d_garb;
    assign div_r    = div_done ? d_r : ~d_garb;

    int total = 0, bad = 0;
    int n_starts = 0, exp_starts = 0, exp_ready_cyc = -1;

    typedef struct {
        logic [MSB:0] data;
        logic [4:0]   rd;
        int           cyc;
    } exp_t;
    exp_t exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit is_special(input logic [1:0] op, input logic [MSB:0] a, input logic [MSB:0] b);
        logic [MSB:0] min_neg;
        min_neg = 1'b1 << MSB;
        return (b == 0) || (!op[0] && a == min_neg && b == '1);
    endfunction

    // RISC-V M-extension semantics in plain arithmetic
    function automatic logic [MSB:0] ref_res(input logic [1:0] op, input logic [MSB:0] a, input logic [MSB:0] b);
        logic signed [MSB:0] sa, sb;
        logic [MSB:0] min_neg;
        sa = a; sb = b;
        min_neg = 1'b1 << MSB;
        case (op)
            2'd0: if (b == 0) return '1; else if (a == min_neg && b == '1) return a; else return sa / sb;
            2'd1: if (b == 0) return '1; else return a / b;
            2'd2: if (b == 0) return a; else if (a == min_neg && b == '1) return '0; else return sa % sb;
            default: if (b == 0) return a; else return a % b;
        endcase
    endfunction

    // Monitor: pops the scoreboard on every response strobe and polices the start handshake
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (div_start) begin
                    n_starts++;
                    chk("start_while_busy", div_done, 1'b1);
                end
                if (!div_done) begin
                    chk("opnd_a_stable", div_a, d_a);
                    chk("opnd_b_stable", div_b, d_b);
                end
                if (rsp_valid) begin
                    if (exp_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_rsp: got data %0h rd %0d, expected none (cycle %0d)", rsp_data, rsp_rd, cyc);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rsp_data", rsp_data, e.data);
                        chk("rsp_rd", rsp_rd, e.rd);
                        chk("rsp_cycle", cyc, e.cyc);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic wait_ready();
        int waited = 0;
        while (!req_ready && waited < 300) begin step(); waited++; end
        if (!req_ready) begin
            total++; bad++;
            $display("FAIL ready_timeout: ready stayed 0 for %0d cycles", waited);
        end else if (exp_ready_cyc >= 0) begin
            chk("ready_return", cyc, exp_ready_cyc);
        end
        exp_ready_cyc = -1;
    endtask

    // ctl > 0: flush in that cycle after accept; ctl < 0: reset in cycle -ctl
    task automatic issue(input logic [1:0] op, input logic [MSB:0] a, input logic [MSB:0] b,
                         input logic [4:0] rd, input int ctl, input int gap);
        int t0, f;
        bit sp;
        wait_ready();
        repeat (gap) step();
        sp = is_special(op, a, b);
        req_valid = 1'b1; req_op = op; req_rs1 = a; req_rs2 = b; req_rd = rd;
        t0 = cyc;
        if (!sp) exp_starts++;
        if (ctl == 0) exp_q.push_back('{ref_res(op, a, b), rd, t0 + (sp ? 1 : LAT_N)});
        step();
        req_valid = 1'b0; req_rs1 = $urandom; req_rs2 = $urandom; req_rd = 5'($urandom);
        if (ctl > 0) begin
            repeat (ctl - 1) step();
            flush = 1'b1;
            step();
            flush = 1'b0;
            f = (ctl + 1 > MSB + 4) ? ctl + 1 : MSB + 4;
            exp_ready_cyc = sp ? t0 + 2 : t0 + f + 1;
        end else if (ctl < 0) begin
            repeat (-ctl - 1) step();
            reset = 1'b1;
            step();
            reset = 1'b0;
            chk("rst_ready", req_ready, 1'b1);
            chk("rst_rsp_valid", rsp_valid, 1'b0);
            chk("rst_rsp_data", rsp_data, 0);
            chk("rst_rsp_rd", rsp_rd, 0);
            chk("rst_start", div_start, 1'b0);
            chk("rst_divident", div_a, 0);
            chk("rst_divisor", div_b, 0);
            exp_ready_cyc = cyc;
        end else begin
            exp_ready_cyc = t0 + (sp ? 2 : LAT_N + 1);
        end
    endtask

    initial begin
        logic [1:0]   op;
        logic [MSB:0] a, b;
        int cls, ctl, n0;
        reset = 1'b1; req_valid = 1'b0; flush = 1'b0;
        req_op = 2'd0; req_rs1 = '0; req_rs2 = '0; req_rd = 5'd0;
        repeat (3) step();
        reset = 1'b0;
        chk("init_ready", req_ready, 1'b1);
        chk("init_rsp_valid", rsp_valid, 1'b0);
        chk("init_rsp_data", rsp_data, 0);
        chk("init_start", div_start, 1'b0);
        chk("init_divident", div_a, 0);

        issue(2'd1, 32'd100, 32'd7, 5'd5, 0, 0);
        issue(2'd0, -32'sd7, 32'd2, 5'd1, 0, 0);
        issue(2'd2, -32'sd7, 32'd2, 5'd2, 0, 0);
        issue(2'd2, 32'd7, -32'sd2, 5'd3, 0, 1);
        issue(2'd3, 32'hFFFF_FFF9, 32'd2, 5'd4, 0, 0);
        n0 = exp_starts;
        issue(2'd2, 32'h1234, 32'd0, 5'd6, 0, 0);
        issue(2'd0, 32'hDEAD_BEEF, 32'd0, 5'd7, 0, 0);
        issue(2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 0, 0);
        issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 0, 0);
        issue(2'd1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 0, 0);
        issue(2'd1, 32'd1000, 32'd3, 5'd11, 10, 0);
        issue(2'd1, 32'd1000, 32'd3, 5'd12, 0, 0);
        issue(2'd3, 32'd55, 32'd0, 5'd13, 1, 0);
        issue(2'd0, 32'd77, 32'd5, 5'd14, MSB + 4, 0);
        issue(2'd1, 32'd500, 32'd9, 5'd15, -15, 0);
        issue(2'd1, 32'd9, 32'd3, 5'd16, 0, 0);

        // Flush together with a request in IDLE must accept nothing
        wait_ready();
        n0 = n_starts;
        req_valid = 1'b1; flush = 1'b1; req_op = 2'd1; req_rs1 = 32'd40; req_rs2 = 32'd4;
        step();
        req_valid = 1'b0; flush = 1'b0;
        chk("idle_flush_ready", req_ready, 1'b1);
        repeat (3) step();
        chk("idle_flush_nostart", n_starts, n0);

        for (int i = 0; i < 40; i++) begin
            op  = 2'($urandom_range(0, 3));
            cls = $urandom_range(0, 9);
            a   = $urandom;
            b   = $urandom;
            if (cls == 0) b = '0;
            else if (cls == 1) begin a = 32'h8000_0000; b = '1; end
            else if (cls <= 4) begin
                a = $urandom_range(0, 60); b = $urandom_range(1, 9);
                if ($urandom_range(0, 1) == 1) a = -a;
                if ($urandom_range(0, 1) == 1) b = -b;
            end
            ctl = 0;
            if ($urandom_range(0, 6) == 0)
                ctl = is_special(op, a, b) ? 1 : $urandom_range(1, MSB + 4);
            issue(op, a, b, 5'($urandom), ctl, $urandom_range(0, 2));
        end

        wait_ready();
        repeat (3) step();
        chk("scoreboard_empty", exp_q.size(), 0);
        chk("start_count", n_starts, exp_starts);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
